// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready intake, per-frame parity/stop selection.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 14,
  parameter int DATA_BITS    = 8,
  parameter int MSB_FIRST    = 1
) (
  input  logic                 clk_3125,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_type,
  input  logic                 stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                 send_break,
`endif
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DONE_CNT = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MAB
  } state_t;

  state_t                 state_reg;
  logic [CW-1:0]          cnt_reg;
  logic [BW-1:0]          bit_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   par_en_reg;
  logic                   par_bit_reg;
  logic                   stop2_reg;
  logic                   stop_second_reg;
  logic                   bit_end;
  logic                   last_stop;

  // Next payload bit to put on the line, and the register after it has been consumed.
  function automatic logic head(input logic [DATA_BITS-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_BITS-1] : v[0];
  endfunction

  function automatic logic [DATA_BITS-1:0] advance(input logic [DATA_BITS-1:0] v);
    return (MSB_FIRST != 0) ? {v[DATA_BITS-2:0], 1'b0} : {1'b0, v[DATA_BITS-1:1]};
  endfunction

  assign bit_end   = (cnt_reg == LAST_CNT);
  assign last_stop = !stop2_reg || stop_second_reg;

`ifdef UART_TX_BREAK_EN
  assign tx_ready = (state_reg == S_IDLE) && !send_break;
`else
  assign tx_ready = (state_reg == S_IDLE);
`endif

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      bit_reg         <= '0;
      shift_reg       <= '0;
      par_en_reg      <= 1'b0;
      par_bit_reg     <= 1'b0;
      stop2_reg       <= 1'b0;
      stop_second_reg <= 1'b0;
      tx              <= 1'b1;
      tx_busy         <= 1'b0;
      tx_done         <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state_reg != S_IDLE && state_reg != S_BREAK)
        cnt_reg <= bit_end ? '0 : cnt_reg + CW'(1);

      case (state_reg)
        S_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (send_break) begin
            state_reg <= S_BREAK;
            tx        <= 1'b0;
          end else
`endif
          if (tx_valid && tx_ready) begin
            shift_reg       <= tx_data;
            par_en_reg      <= parity_en;
            par_bit_reg     <= (^tx_data) ^ parity_type;
            stop2_reg       <= stop2;
            stop_second_reg <= 1'b0;
            cnt_reg         <= '0;
            tx              <= 1'b0;
            tx_busy         <= 1'b1;
            state_reg       <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx        <= head(shift_reg);
            shift_reg <= advance(shift_reg);
            bit_reg   <= '0;
            state_reg <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_reg == LAST_BIT) begin
              tx        <= par_en_reg ? par_bit_reg : 1'b1;
              state_reg <= par_en_reg ? S_PARITY : S_STOP;
            end else begin
              tx        <= head(shift_reg);
              shift_reg <= advance(shift_reg);
              bit_reg   <= bit_reg + BW'(1);
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            tx        <= 1'b1;
            state_reg <= S_STOP;
          end
        end
        S_STOP: begin
          // Pulse lands in the final clock of the last stop bit.
          if (last_stop && cnt_reg == DONE_CNT)
            tx_done <= 1'b1;
          if (bit_end) begin
            if (last_stop) begin
              tx_busy   <= 1'b0;
              state_reg <= S_IDLE;
            end else begin
              stop_second_reg <= 1'b1;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        S_BREAK: begin
          if (!send_break) begin
            tx        <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= S_MAB;
          end
        end
        S_MAB: begin
          if (bit_end)
            state_reg <= S_IDLE;
        end
`endif
        default: begin
          tx        <= 1'b1;
          tx_busy   <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised successor of the fixed 8-bit UART transmitter. Data width, bit order and bit period are set per instance. Parity enable/type and stop-bit count are selectable per frame. Replaces the tx_start pulse with a valid/ready handshake and adds an explicit busy flag. Sits between the command/telemetry logic and the board UART pin, clocked from clk_3125.

Parameters:
CLKS_PER_BIT, 14, clocks per serial bit; legal range >= 2; bit counter width is $clog2(CLKS_PER_BIT).
DATA_BITS, 8, payload width; legal range 5..9.
MSB_FIRST, 1, 1 = data sent MSB first; 0 = LSB first.

Ports:
clk_3125  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
tx_data  in  DATA_BITS  payload; sampled only on handshake.
tx_valid  in  1  payload available.
tx_ready  out  1  block can accept; high only in IDLE.
parity_en  in  1  1 = insert parity bit; sampled on handshake.
parity_type  in  1  0 = even, 1 = odd; sampled on handshake.
stop2  in  1  0 = one stop bit, 1 = two stop bits; sampled on handshake.
tx  out  1  serial line; idle/mark = 1.
tx_busy  out  1  high from the handshake edge to the end of the frame.
tx_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (async, rst_n=0): tx=1, tx_busy=0, tx_done=0, tx_ready=1, state IDLE, counters 0. Reset mid-frame aborts the frame: tx goes to 1 immediately and no tx_done is produced.
- States: IDLE -> START -> DATA -> PARITY (skipped if parity_en=0) -> STOP -> IDLE.
- Handshake: transfer occurs on the edge where tx_valid && tx_ready; call it edge E.
  - On E: latch tx_data, parity_en, parity_type and stop2; compute parity = (^tx_data) ^ parity_type; tx<=0; tx_busy<=1; enter START.
  - Inputs changing after E do not affect the frame in flight.
- Bit timing: every bit (start, data, parity, each stop) lasts exactly CLKS_PER_BIT clocks. tx changes only on bit boundaries, with no glitches. Bit k starts at edge E + k*CLKS_PER_BIT.
- Data order: MSB_FIRST=1 sends tx_data[DATA_BITS-1] down to [0]; MSB_FIRST=0 sends [0] upward.
- Frame length: N = 1 + DATA_BITS + parity_en + 1 + stop2 bits.
- End of frame:
  - tx_done=1 for exactly one clock, on the edge E + N*CLKS_PER_BIT - 1 (i.e. during the final clock of the last stop bit).
  - On the next edge: tx_done=0, tx_busy=0, state IDLE, tx_ready=1.
- Back-to-back: if tx_valid is held high, the next handshake occurs on the first IDLE edge. The next start bit therefore begins at E + N*CLKS_PER_BIT + 1 (one extra mark clock between frames).
- tx_ready is a combinational decode of state==IDLE (plus break gating below). It does not depend on tx_valid.
- Stop bits are always 1. No framing/overrun status; upstream must honour tx_ready.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input send_break (1 bit).
  - In IDLE with send_break=1: tx=0 and tx_ready=0 for as long as send_break stays high. tx_valid is ignored during this time.
  - On deassert: tx=1 for exactly CLKS_PER_BIT clocks (mark-after-break) with tx_ready=0, then tx_ready=1.
  - If send_break and tx_valid are both high in IDLE, break wins.
  - send_break asserted mid-frame is ignored until the frame completes.
- Undefined: port absent; tx is low only during start, data and parity bits.

Test Plan:
1. Defaults, tx_data=0xA5, parity_en=1, parity_type=0, stop2=0 -> tx = 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 14 clks; tx_done pulse at E+153; tx_ready=1 at E+154.
2. Same data with parity_type=1 -> parity bit = 1; all other bits and timing identical.
3. parity_en=0, stop2=1, tx_data=0x3C -> 0,0,0,1,1,1,1,0,0,1,1; 11 bits = 154 clks; no parity bit.
4. MSB_FIRST=0, DATA_BITS=7, CLKS_PER_BIT=4, tx_data=7'h41, no parity -> 0,1,0,0,0,0,0,1,1; tx_done at E+35.
5. tx_valid held high for two frames (0x55 then 0xAA) -> second start bit begins at E1+155; exactly one mark clock between frames; two tx_done pulses.
6. rst_n pulsed low at E+50 of a frame -> tx=1 asynchronously; no tx_done; tx_busy=0; next handshake produces a full, correct frame.
